// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD constants and elaboration-time helper functions.
package bin2bcd_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Value every digit takes when the input is beyond the displayable range.
  localparam logic [3:0] BCD_NINE = 4'h9;

  // 10^digits held at 64 bits so the overflow compare cannot wrap for any
  // realistic digit count.
  function automatic logic [63:0] pow10(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // Number of bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adjust.sv
// Single BCD digit correction cell for the double-dabble algorithm:
// a digit of five or more gets three added so that the following left
// shift carries correctly into the next decimal digit.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Add three when the digit would reach ten or more after doubling.
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter feeding the two-digit seven-segment
// driver. One binary bit is consumed per clock; the packed BCD result and
// the overflow flag are held stable between conversions so the driver can
// sample them on its own refresh tick. Inputs of 10^DIGITS or more show
// as all nines with ovf raised.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int IN_W   = 7,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W     = 4 * DIGITS;
  localparam int CNT_BITS  = clog2(IN_W);
  localparam int CNT_W     = (CNT_BITS < 1) ? 1 : CNT_BITS;
  localparam logic [63:0] LIMIT = pow10(DIGITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_W - 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

  state_t              state;
  logic [IN_W-1:0]     shift_reg;
  logic [BCD_W-1:0]    scratch;
  logic [BCD_W-1:0]    adjusted;
  logic [BCD_W-1:0]    scratch_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic                ovf_pending;
  logic                bin_over;

  // The operand is compared at 64 bits against 10^DIGITS; when that limit
  // exceeds the largest IN_W-bit value this is simply never true.
  assign bin_over = (64'(bin) >= LIMIT);

  // One correction cell per BCD digit of the scratch register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit    (scratch[4*g +: 4]),
      .adjusted (adjusted[4*g +: 4])
    );
  end

  // Shift the corrected scratch left, pulling in the next operand bit; the
  // carry out of the top digit is dropped since it only occurs on overflow.
  assign scratch_next = BCD_W'({adjusted, shift_reg[IN_W-1]});

  // Control FSM together with the datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      scratch     <= '0;
      bit_cnt     <= '0;
      ovf_pending <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd         <= '0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_reg   <= bin;
            scratch     <= '0;
            bit_cnt     <= '0;
            ovf_pending <= bin_over;
            busy        <= 1'b1;
            state       <= CONV;
          end
        end
        CONV: begin
          scratch   <= scratch_next;
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + 1'b1;
          done      <= 1'b0;
          if (bit_cnt == LAST_BIT) begin
            bcd     <= ovf_pending ? ALL_NINES : scratch_next;
            ovf     <= ovf_pending;
            done    <= 1'b1;
            busy    <= 1'b0;
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: a default 7-bit/2-digit
// instance and an 8-bit/3-digit instance sharing clock and reset.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a;
  logic [6:0]  bin_a;
  logic        busy_a, done_a, ovf_a;
  logic [7:0]  bcd_a;
  logic        start_b;
  logic [7:0]  bin_b;
  logic        busy_b, done_b, ovf_b;
  logic [11:0] bcd_b;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.IN_W(7), .DIGITS(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a)
  );

  bin2bcd_seq #(.IN_W(8), .DIGITS(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Guard against a hung simulation.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run one conversion on the 7-bit instance and return result, flag,
  // number of observed busy cycles and whether done arrived in time.
  task automatic convert_a(input logic [6:0] v, output logic [7:0] r,
                           output logic o, output int bc, output bit ok);
    start_a = 1'b1;
    bin_a   = v;
    tick;
    start_a = 1'b0;
    bc = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_a) begin
        ok = 1'b1;
        break;
      end
      if (busy_a) bc++;
      tick;
    end
    r = bcd_a;
    o = ovf_a;
  endtask

  task automatic test_reset;
    reset = 1'b1; start_a = 1'b0; bin_a = '0; start_b = 1'b0; bin_b = '0;
    #3;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done_a); end
    checks++; if (bcd_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_bcd got %h expected 00", bcd_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b expected 0", ovf_a); end
    checks++; if (bcd_b !== 12'h000 || busy_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_b got bcd %h busy %b expected 000 0", bcd_b, busy_b); end
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_zero;
    logic [7:0] r; logic o; int bc; bit ok;
    convert_a(7'd0, r, o, bc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL zero_done got %b expected 1", ok); end
    checks++; if (bc != 7) begin errors++; $display("[TB] FAIL zero_busy_cycles got %0d expected 7", bc); end
    checks++; if (r !== 8'h00 || o !== 1'b0) begin errors++; $display("[TB] FAIL zero_result got %h/%b expected 00/0", r, o); end
    tick;
    checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_pulse got %b expected 0", done_a); end
  endtask

  task automatic test_values;
    logic [7:0] r; logic o; int bc; bit ok;
    convert_a(7'd42, r, o, bc, ok);
    checks++; if (!ok || r !== 8'h42 || o !== 1'b0) begin errors++; $display("[TB] FAIL val42 got %h/%b ok %b expected 42/0", r, o, ok); end
    convert_a(7'd99, r, o, bc, ok);
    checks++; if (!ok || r !== 8'h99 || o !== 1'b0) begin errors++; $display("[TB] FAIL val99 got %h/%b ok %b expected 99/0", r, o, ok); end
    repeat (3) tick;
    checks++; if (bcd_a !== 8'h99 || ovf_a !== 1'b0) begin errors++; $display("[TB] FAIL hold99 got %h/%b expected 99/0", bcd_a, ovf_a); end
  endtask

  task automatic test_sweep;
    logic [7:0] r, expv; logic o; int bc; bit ok;
    for (int v = 0; v < 100; v++) begin
      expv = {4'(v / 10), 4'(v % 10)};
      convert_a(7'(v), r, o, bc, ok);
      checks++;
      if (!ok || r !== expv || o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sweep_%0d got %h/%b ok %b expected %h/0", v, r, o, ok, expv);
      end
    end
  endtask

  task automatic test_overflow;
    logic [7:0] r; logic o; int bc; bit ok;
    convert_a(7'd100, r, o, bc, ok);
    checks++; if (!ok || r !== 8'h99 || o !== 1'b1) begin errors++; $display("[TB] FAIL ovf100 got %h/%b ok %b expected 99/1", r, o, ok); end
    convert_a(7'd127, r, o, bc, ok);
    checks++; if (!ok || r !== 8'h99 || o !== 1'b1) begin errors++; $display("[TB] FAIL ovf127 got %h/%b ok %b expected 99/1", r, o, ok); end
    convert_a(7'd5, r, o, bc, ok);
    checks++; if (!ok || r !== 8'h05 || o !== 1'b0) begin errors++; $display("[TB] FAIL after_ovf5 got %h/%b ok %b expected 05/0", r, o, ok); end
  endtask

  task automatic test_back_to_back;
    int  n_done;
    bit  busy_gap;
    bit  ok;
    n_done   = 0;
    busy_gap = 1'b0;
    start_a  = 1'b1;
    bin_a    = 7'd37;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (done_a) begin
        n_done++;
        if (n_done == 1) begin
          checks++; if (k != 7 || bcd_a !== 8'h37) begin errors++; $display("[TB] FAIL b2b_first got k %0d bcd %h expected k 7 bcd 37", k, bcd_a); end
        end else if (n_done == 2) begin
          checks++; if (k != 15 || bcd_a !== 8'h12) begin errors++; $display("[TB] FAIL b2b_second got k %0d bcd %h expected k 15 bcd 12", k, bcd_a); end
        end
      end else if (busy_a !== 1'b1) begin
        busy_gap = 1'b1;
      end
      if (k == 2) bin_a = 7'd12;
    end
    start_a = 1'b0;
    checks++; if (n_done != 2) begin errors++; $display("[TB] FAIL b2b_count got %0d expected 2", n_done); end
    checks++; if (busy_gap) begin errors++; $display("[TB] FAIL b2b_busy got gap expected continuous"); end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done_a) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || bcd_a !== 8'h12) begin errors++; $display("[TB] FAIL b2b_third got %h ok %b expected 12", bcd_a, ok); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] r; logic o; int bc; bit ok;
    bit saw_done;
    start_a = 1'b1;
    bin_a   = 7'd88;
    tick;
    start_a = 1'b0;
    tick; tick; tick;
    reset = 1'b1;
    #1;
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ctrl got busy %b done %b expected 0 0", busy_a, done_a); end
    checks++; if (bcd_a !== 8'h00 || ovf_a !== 1'b0) begin errors++; $display("[TB] FAIL midreset_result got %h/%b expected 00/0", bcd_a, ovf_a); end
    #2;
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done_a) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("[TB] FAIL midreset_nodone got pulse expected none"); end
    convert_a(7'd88, r, o, bc, ok);
    checks++; if (!ok || r !== 8'h88 || o !== 1'b0) begin errors++; $display("[TB] FAIL midreset_fresh got %h/%b ok %b expected 88/0", r, o, ok); end
  endtask

  task automatic test_wide;
    int bc; bit ok;
    start_b = 1'b1;
    bin_b   = 8'd255;
    tick;
    start_b = 1'b0;
    bc = 0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_b) begin ok = 1'b1; break; end
      if (busy_b) bc++;
      tick;
    end
    checks++; if (!ok || bc != 8) begin errors++; $display("[TB] FAIL wide_busy got %0d ok %b expected 8", bc, ok); end
    checks++; if (bcd_b !== 12'h255 || ovf_b !== 1'b0) begin errors++; $display("[TB] FAIL wide255 got %h/%b expected 255/0", bcd_b, ovf_b); end
    start_b = 1'b1;
    bin_b   = 8'd200;
    tick;
    start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_b) begin ok = 1'b1; break; end
      tick;
    end
    checks++; if (!ok || bcd_b !== 12'h200 || ovf_b !== 1'b0) begin errors++; $display("[TB] FAIL wide200 got %h/%b ok %b expected 200/0", bcd_b, ovf_b, ok); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_values;
    test_sweep;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    test_wide;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
